// File: rtl/voxel_broadcaster.sv
// Frame sequencer feeding the pixel shader array: streams the voxel list out of a
// sync-read RAM one voxel per rasterize pass, then runs a single shade pass.
module voxel_broadcaster #(
    parameter int COORD_BITS   = 8,
    parameter int FRAC_BITS    = 8,
    parameter int PALETTE_BITS = 8,
    parameter int ADDR_BITS    = 10,
    parameter int TIMEOUT      = 255
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic                                 start,
    input  logic                                 abort,
    input  logic [ADDR_BITS:0]                   voxel_count,
    input  logic [COORD_BITS+FRAC_BITS-1:0]      cam_pos_in_x,
    input  logic [COORD_BITS+FRAC_BITS-1:0]      cam_pos_in_y,
    input  logic [COORD_BITS+FRAC_BITS-1:0]      cam_pos_in_z,
    input  logic [COORD_BITS+FRAC_BITS-1:0]      cam_look_in_x,
    input  logic [COORD_BITS+FRAC_BITS-1:0]      cam_look_in_y,
    input  logic [COORD_BITS+FRAC_BITS-1:0]      cam_look_in_z,
    output logic                                 mem_rd_en,
    output logic [ADDR_BITS-1:0]                 mem_addr,
    input  logic [3*COORD_BITS+PALETTE_BITS-1:0] mem_rdata,
    output logic [COORD_BITS-1:0]                voxel_x,
    output logic [COORD_BITS-1:0]                voxel_y,
    output logic [COORD_BITS-1:0]                voxel_z,
    output logic [PALETTE_BITS-1:0]              voxel_id,
    output logic [COORD_BITS+FRAC_BITS-1:0]      cam_pos_x,
    output logic [COORD_BITS+FRAC_BITS-1:0]      cam_pos_y,
    output logic [COORD_BITS+FRAC_BITS-1:0]      cam_pos_z,
    output logic [COORD_BITS+FRAC_BITS-1:0]      cam_look_x,
    output logic [COORD_BITS+FRAC_BITS-1:0]      cam_look_y,
    output logic [COORD_BITS+FRAC_BITS-1:0]      cam_look_z,
    output logic                                 do_rasterize,
    output logic                                 do_shade,
    input  logic                                 all_rasterized,
    input  logic                                 all_shaded,
    output logic                                 busy,
    output logic                                 frame_done,
    output logic                                 timeout_err
);

    localparam int CNT_BITS = ADDR_BITS + 1;
    localparam int WD_BITS  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_BITS-1:0] MAX_COUNT = {1'b1, {ADDR_BITS{1'b0}}};
    localparam logic [WD_BITS-1:0]  WD_LAST   = WD_BITS'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        RASTER,
        SHADE,
        FINISH
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [CNT_BITS-1:0]  count_q;
    logic [CNT_BITS-1:0]  clamped_count;
    logic [ADDR_BITS-1:0] index;
    logic [ADDR_BITS-1:0] next_index;
    logic [WD_BITS-1:0]   wd_count;
    logic                 accept;
    logic                 timed_out;
    logic                 last_voxel;
    logic                 wd_expired;

    assign clamped_count = (voxel_count > MAX_COUNT) ? MAX_COUNT : voxel_count;
    assign last_voxel    = ({1'b0, index} == (count_q - CNT_BITS'(1)));
    assign wd_expired    = (wd_count == WD_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Done is checked before the watchdog, so a done arriving on the final allowed cycle still counts.
    always_comb begin
        next_state = state;
        next_index = index;
        accept     = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_index = '0;
                    next_state = (voxel_count == '0) ? SHADE : FETCH;
                end
            end
            FETCH:  next_state = LATCH;
            LATCH:  next_state = RASTER;
            RASTER: begin
                if (all_rasterized) begin
                    if (last_voxel) begin
                        next_state = SHADE;
                    end else begin
                        next_index = index + ADDR_BITS'(1);
                        next_state = FETCH;
                    end
                end else if (wd_expired) begin
                    timed_out  = 1'b1;
                    next_state = FINISH;
                end
            end
            SHADE: begin
                if (all_shaded) begin
                    next_state = FINISH;
                end else if (wd_expired) begin
                    timed_out  = 1'b1;
                    next_state = FINISH;
                end
            end
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (abort) begin
            next_state = IDLE;
            next_index = index;
            accept     = 1'b0;
            timed_out  = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q     <= '0;
            index       <= '0;
            wd_count    <= '0;
            timeout_err <= 1'b0;
            cam_pos_x   <= '0;
            cam_pos_y   <= '0;
            cam_pos_z   <= '0;
            cam_look_x  <= '0;
            cam_look_y  <= '0;
            cam_look_z  <= '0;
            voxel_x     <= '0;
            voxel_y     <= '0;
            voxel_z     <= '0;
            voxel_id    <= '0;
        end else begin
            index <= next_index;
            if (accept) begin
                count_q    <= clamped_count;
                cam_pos_x  <= cam_pos_in_x;
                cam_pos_y  <= cam_pos_in_y;
                cam_pos_z  <= cam_pos_in_z;
                cam_look_x <= cam_look_in_x;
                cam_look_y <= cam_look_in_y;
                cam_look_z <= cam_look_in_z;
            end
            if (accept) begin
                timeout_err <= 1'b0;
            end else if (timed_out) begin
                timeout_err <= 1'b1;
            end
            // Any state change restarts the watchdog, so it always starts at zero on entering a wait.
            if (next_state != state) begin
                wd_count <= '0;
            end else if (state == RASTER || state == SHADE) begin
                wd_count <= wd_count + WD_BITS'(1);
            end
            if (state == LATCH) begin
                {voxel_id, voxel_z, voxel_y, voxel_x} <= mem_rdata;
            end
        end
    end

    // Strobes are decoded from the next state so they are glitch-free and aligned with the state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_rd_en    <= 1'b0;
            mem_addr     <= '0;
            do_rasterize <= 1'b0;
            do_shade     <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            mem_rd_en    <= (next_state == FETCH);
            do_rasterize <= (next_state == RASTER);
            do_shade     <= (next_state == SHADE);
            busy         <= (next_state != IDLE);
            frame_done   <= (next_state == FINISH);
            if (next_state == FETCH) begin
                mem_addr <= next_index;
            end
        end
    end

endmodule

// File: tb/tb_voxel_broadcaster.sv
// Randomized self-checking bench for voxel_broadcaster: RAM and shader-array models
// drive the DUT while a frame-level model predicts reads, windows, latency and errors.
module tb_voxel_broadcaster;

    localparam int T     = 4;
    localparam int DEPTH = 1024;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [10:0] voxel_count = '0;
    logic [15:0] cam_pos_in_x = '0, cam_pos_in_y = '0, cam_pos_in_z = '0;
    logic [15:0] cam_look_in_x = '0, cam_look_in_y = '0, cam_look_in_z = '0;
    logic        mem_rd_en;
    logic [9:0]  mem_addr;
    logic [31:0] mem_rdata = '0;
    logic [7:0]  voxel_x, voxel_y, voxel_z, voxel_id;
    logic [15:0] cam_pos_x, cam_pos_y, cam_pos_z, cam_look_x, cam_look_y, cam_look_z;
    logic        do_rasterize, do_shade, busy, frame_done, timeout_err;
    logic        all_rasterized = 1'b0;
    logic        all_shaded = 1'b0;

    logic [95:0]  cam_out;
    logic [31:0]  vox_out;
    logic [143:0] all_out;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [31:0] ram [DEPTH];
    int          ras_delay [2048];
    int          shade_delay = 0;
    bit          noise = 1'b0;
    bit          clear_req = 1'b0;
    bit          cam_check = 1'b0;
    logic [95:0] exp_cam = '0;

    int          addr_q[$];
    logic [31:0] vox_q[$];
    int          ras_len_q[$];
    int          shade_len_q[$];
    int          done_q[$];
    bit          cam_bad = 1'b0, vox_unstable = 1'b0, overlap = 1'b0;

    assign cam_out = {cam_pos_x, cam_pos_y, cam_pos_z, cam_look_x, cam_look_y, cam_look_z};
    assign vox_out = {voxel_id, voxel_z, voxel_y, voxel_x};
    assign all_out = {mem_rd_en, mem_addr, vox_out, cam_out, do_rasterize, do_shade,
                      busy, frame_done, timeout_err};

    voxel_broadcaster #(
        .COORD_BITS(8), .FRAC_BITS(8), .PALETTE_BITS(8), .ADDR_BITS(10), .TIMEOUT(T)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
        .voxel_count(voxel_count),
        .cam_pos_in_x(cam_pos_in_x), .cam_pos_in_y(cam_pos_in_y), .cam_pos_in_z(cam_pos_in_z),
        .cam_look_in_x(cam_look_in_x), .cam_look_in_y(cam_look_in_y), .cam_look_in_z(cam_look_in_z),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .voxel_x(voxel_x), .voxel_y(voxel_y), .voxel_z(voxel_z), .voxel_id(voxel_id),
        .cam_pos_x(cam_pos_x), .cam_pos_y(cam_pos_y), .cam_pos_z(cam_pos_z),
        .cam_look_x(cam_look_x), .cam_look_y(cam_look_y), .cam_look_z(cam_look_z),
        .do_rasterize(do_rasterize), .do_shade(do_shade),
        .all_rasterized(all_rasterized), .all_shaded(all_shaded),
        .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Sync-read RAM; garbage on idle cycles exposes a latch on the wrong cycle.
    always @(posedge clock) mem_rdata <= mem_rd_en ? ram[mem_addr] : $urandom;

    // Shader array: done after a per-window delay; random chatter outside its window.
    int ras_idx = 0, ras_cnt = 0, cur_delay = 0, shd_cnt = 0;
    bit ras_on = 1'b0;
    always @(negedge clock) begin
        if (clear_req) ras_idx = 0;
        if (do_rasterize) begin
            if (!ras_on) begin
                ras_on = 1'b1;
                ras_cnt = 0;
                cur_delay = (ras_idx < 2048) ? ras_delay[ras_idx] : 99;
                ras_idx++;
            end
            ras_cnt++;
            all_rasterized = (ras_cnt > cur_delay);
        end else begin
            ras_on = 1'b0;
            all_rasterized = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        if (do_shade) begin
            shd_cnt++;
            all_shaded = (shd_cnt > shade_delay);
        end else begin
            shd_cnt = 0;
            all_shaded = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    logic [31:0] cur_vox = '0;
    int          ras_len = 0, shade_len = 0;
    logic        prev_ras = 1'b0, prev_shade = 1'b0;
    always @(negedge clock) begin
        if (clear_req) begin
            addr_q.delete(); vox_q.delete(); ras_len_q.delete();
            shade_len_q.delete(); done_q.delete();
            cam_bad = 1'b0; vox_unstable = 1'b0; overlap = 1'b0;
        end
        if (mem_rd_en) addr_q.push_back(int'(mem_addr));
        if (do_rasterize) begin
            if (!prev_ras) begin
                cur_vox = vox_out;
                vox_q.push_back(vox_out);
                ras_len = 0;
            end else if (vox_out != cur_vox) begin
                vox_unstable = 1'b1;
            end
            ras_len++;
        end else if (prev_ras) begin
            ras_len_q.push_back(ras_len);
        end
        if (do_shade) begin
            if (!prev_shade) shade_len = 0;
            shade_len++;
        end else if (prev_shade) begin
            shade_len_q.push_back(shade_len);
        end
        if (frame_done) done_q.push_back(cyc);
        if (do_rasterize && do_shade) overlap = 1'b1;
        if (cam_check && cam_out != exp_cam) cam_bad = 1'b1;
        prev_ras = do_rasterize;
        prev_shade = do_shade;
    end

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        tests++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic int pick_delay();
        if ($urandom_range(0, 7) == 0) return 99;
        return int'($urandom_range(0, T - 1));
    endfunction

    task automatic apply_stimulus(input int count, output int s);
        logic [95:0] cam;
        clear_req = 1'b1;
        @(negedge clock); #1;
        clear_req = 1'b0;
        @(posedge clock); #1;
        cam = {$urandom, $urandom, $urandom};
        {cam_pos_in_x, cam_pos_in_y, cam_pos_in_z, cam_look_in_x, cam_look_in_y, cam_look_in_z} = cam;
        voxel_count = 11'(count);
        start = 1'b1;
        cam_check = 1'b0;
        s = cyc;
        @(posedge clock); #1;
        start = 1'b0;
        exp_cam = cam;
        cam_check = 1'b1;
        check_output("busy_after_start", busy, 1);
        check_output("err_cleared_by_start", timeout_err, 0);
    endtask

    // Frame model: each voxel costs fetch + latch + its window; shade window; one finish cycle.
    task automatic run_frame(input int count, input int sd, input bit poke);
        int n, exp_lat, s, budget, w, n_read;
        bit exp_to;
        int exp_win[$];
        int exp_shd[$];
        n = (count > DEPTH) ? DEPTH : count;
        exp_lat = 1;
        exp_to = 1'b0;
        n_read = 0;
        for (int i = 0; i < n && !exp_to; i++) begin
            w = (ras_delay[i] + 1 > T) ? T : ras_delay[i] + 1;
            exp_win.push_back(w);
            exp_lat += 2 + w;
            n_read++;
            if (ras_delay[i] + 1 > T) exp_to = 1'b1;
        end
        if (!exp_to) begin
            w = (sd + 1 > T) ? T : sd + 1;
            exp_shd.push_back(w);
            exp_lat += w;
            if (sd + 1 > T) exp_to = 1'b1;
        end
        shade_delay = sd;
        apply_stimulus(count, s);
        budget = exp_lat + 20;
        while (done_q.size() == 0 && budget > 0) begin
            if (poke) begin
                start = 1'($urandom_range(0, 1));
                {cam_pos_in_x, cam_pos_in_y, cam_pos_in_z} = {$urandom, $urandom};
                voxel_count = 11'($urandom);
            end
            @(posedge clock); #1;
            budget--;
        end
        start = 1'b0;
        if (done_q.size() == 0) begin
            check_output("frame_done_seen", 0, 1);
            abort = 1'b1;
            @(posedge clock); #1;
            abort = 1'b0;
        end
        repeat (3) @(posedge clock);
        #1;
        check_output("frame_done_count", done_q.size(), 1);
        if (done_q.size() > 0) check_output("frame_latency", done_q[0] - s, exp_lat);
        check_output("read_count", addr_q.size(), n_read);
        for (int i = 0; i < addr_q.size() && i < n_read; i++)
            check_output($sformatf("read_addr[%0d]", i), addr_q[i], i);
        check_output("raster_windows", vox_q.size(), exp_win.size());
        for (int i = 0; i < vox_q.size() && i < exp_win.size(); i++) begin
            check_output($sformatf("voxel[%0d]", i), vox_q[i], ram[i]);
            if (i < ras_len_q.size())
                check_output($sformatf("raster_len[%0d]", i), ras_len_q[i], exp_win[i]);
        end
        check_output("shade_windows", shade_len_q.size(), exp_shd.size());
        if (shade_len_q.size() > 0 && exp_shd.size() > 0)
            check_output("shade_len", shade_len_q[0], exp_shd[0]);
        check_output("timeout_err", timeout_err, exp_to);
        check_output("camera_stable", cam_bad, 0);
        check_output("voxel_stable", vox_unstable, 0);
        check_output("raster_shade_overlap", overlap, 0);
        check_output("idle_after_frame", busy, 0);
    endtask

    initial begin
        #5000000;
        $display("[TB] FAIL global_time_limit: got expired, expected finish");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        int s, budget, cnt;
        for (int i = 0; i < DEPTH; i++) ram[i] = $urandom;
        for (int i = 0; i < 2048; i++) ras_delay[i] = 0;
        ram[0] = 32'h04030201; ram[1] = 32'h08070605; ram[2] = 32'h0c0b0a09;

        repeat (3) @(posedge clock);
        #1;
        check_output("reset_outputs", $countones(all_out), 0);
        reset_n = 1'b1;
        @(posedge clock); #1;
        check_output("reset_idle", busy, 0);

        // Three voxels, shaders done 2 cycles into each window.
        for (int i = 0; i < 3; i++) ras_delay[i] = 2;
        run_frame(3, 1, 1'b0);
        noise = 1'b1;
        // Empty list goes straight to shading.
        run_frame(0, 2, 1'b0);
        // Shaders never finish rasterizing: watchdog ends the frame.
        ras_delay[0] = 99;
        run_frame(3, 0, 1'b0);
        ras_delay[0] = 1;
        run_frame(2, 0, 1'b0);
        run_frame(2, 99, 1'b0);
        // Camera inputs and start toggling while busy must not disturb the frame.
        for (int i = 0; i < 3; i++) ras_delay[i] = 1;
        run_frame(3, 1, 1'b1);

        // Abort in the middle of the second raster window.
        for (int i = 0; i < 3; i++) ras_delay[i] = 3;
        apply_stimulus(3, s);
        budget = 100;
        while (!(vox_q.size() == 2 && do_rasterize) && budget > 0) begin
            @(posedge clock); #1;
            budget--;
        end
        check_output("abort_reached_raster2", budget > 0, 1);
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        check_output("abort_do_rasterize", do_rasterize, 0);
        check_output("abort_busy", busy, 0);
        check_output("abort_rd_en", mem_rd_en, 0);
        repeat (10) @(posedge clock);
        #1;
        check_output("abort_no_frame_done", done_q.size(), 0);
        check_output("abort_camera_kept", cam_bad, 0);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        abort = 1'b0;
        check_output("start_with_abort_busy", busy, 0);
        check_output("start_with_abort_rd_en", mem_rd_en, 0);
        run_frame(3, 0, 1'b0);

        // Reset asserted during the shade pass.
        shade_delay = 3;
        apply_stimulus(0, s);
        budget = 20;
        while (!do_shade && budget > 0) begin
            @(posedge clock); #1;
            budget--;
        end
        check_output("reached_shade", do_shade, 1);
        cam_check = 1'b0;
        @(posedge clock); #2;
        reset_n = 1'b0;
        #1;
        check_output("async_reset_outputs", $countones(all_out), 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_output("reset_release_busy", busy, 0);
        check_output("reset_no_frame_done", done_q.size(), 0);

        // Oversized count is clamped to the full RAM.
        for (int i = 0; i < DEPTH; i++) ras_delay[i] = int'($urandom_range(0, T - 1));
        run_frame(2047, 0, 1'b0);

        for (int f = 0; f < 25; f++) begin
            cnt = int'($urandom_range(0, 12));
            for (int i = 0; i < cnt; i++) ras_delay[i] = pick_delay();
            run_frame(cnt, pick_delay(), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
